// File: rtl/sp_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sp_fifo_ctrl
// Purpose  : Valid/ready FIFO built on a single-port RAM with 1-cycle read
//            latency; the RAM output register serves as the FIFO head.
// Revision : 1.0 - initial release
// ============================================================================
module sp_fifo_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [$clog2(DEPTH+1):0]  count,
    output logic                      full,
    output logic                      empty,
    output logic                      ram_en,
    output logic                      ram_wen,
    output logic [$clog2(DEPTH)-1:0]  ram_addr,
    output logic [WIDTH-1:0]          ram_din,
    input  logic [WIDTH-1:0]          ram_dout
);

    localparam int c_AW  = $clog2(DEPTH);
    localparam int c_RCW = $clog2(DEPTH+1);
    localparam int c_CW  = c_RCW + 1;

    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_RCW-1:0] r_ram_cnt;
    logic             r_out_valid;

    logic             w_pop;
    logic             w_rd_issue;
    logic             w_wr_issue;
    logic [c_AW-1:0]  w_wr_ptr_nxt;
    logic [c_AW-1:0]  w_rd_ptr_nxt;

    // Head is only meaningful outside reset, so gate it before it feeds pop.
    assign out_valid = r_out_valid && !rst;
    assign w_pop     = out_valid && out_ready;

    // Refill reads win over producer writes; the RAM takes one access per cycle.
    assign w_rd_issue = !rst && (r_ram_cnt != '0) && (!r_out_valid || w_pop);
    assign in_ready   = !rst && (r_ram_cnt != c_RCW'(DEPTH)) && !w_rd_issue;
    assign w_wr_issue = in_valid && in_ready;

    assign w_wr_ptr_nxt = (r_wr_ptr == c_AW'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
    assign w_rd_ptr_nxt = (r_rd_ptr == c_AW'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;

    assign ram_en   = w_rd_issue || w_wr_issue;
    assign ram_wen  = w_wr_issue;
    assign ram_addr = w_rd_issue ? r_rd_ptr : r_wr_ptr;
    assign ram_din  = in_data;
    assign out_data = ram_dout;

    assign count = rst ? '0 : (c_CW'(r_ram_cnt) + c_CW'(r_out_valid));
    assign full  = (count == c_CW'(DEPTH+1));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_cnt   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr_issue) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_issue) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            r_ram_cnt <= r_ram_cnt + c_RCW'(w_wr_issue) - c_RCW'(w_rd_issue);
            if (w_rd_issue) begin
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sp_fifo_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sp_fifo_ctrl
// Purpose  : Directed self-checking bench; instance A uses DEPTH=8, B DEPTH=6.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_fifo_ctrl;

    logic clk;
    logic rst;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [7:0] a_in_data, a_out_data, a_ram_din, a_ram_dout;
    logic [4:0] a_count;
    logic       a_full, a_empty, a_ram_en, a_ram_wen;
    logic [2:0] a_ram_addr;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0] b_in_data, b_out_data, b_ram_din, b_ram_dout;
    logic [3:0] b_count;
    logic       b_full, b_empty, b_ram_en, b_ram_wen;
    logic [2:0] b_ram_addr;

    logic [7:0] a_mem [0:7];
    logic [7:0] b_mem [0:5];

    int total = 0;
    int bad   = 0;
    logic [7:0] q [$];

    sp_fifo_ctrl #(.WIDTH(8), .DEPTH(8)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .full(a_full), .empty(a_empty),
        .ram_en(a_ram_en), .ram_wen(a_ram_wen), .ram_addr(a_ram_addr),
        .ram_din(a_ram_din), .ram_dout(a_ram_dout)
    );

    sp_fifo_ctrl #(.WIDTH(8), .DEPTH(6)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .full(b_full), .empty(b_empty),
        .ram_en(b_ram_en), .ram_wen(b_ram_wen), .ram_addr(b_ram_addr),
        .ram_din(b_ram_din), .ram_dout(b_ram_dout)
    );

    // Single-port RAM models: registered read data, held between reads.
    always @(posedge clk) begin
        if (a_ram_en) begin
            if (a_ram_wen) a_mem[a_ram_addr] <= a_ram_din;
            else           a_ram_dout <= a_mem[a_ram_addr];
        end
        if (b_ram_en && b_ram_addr <= 3'd5) begin
            if (b_ram_wen) b_mem[b_ram_addr] <= b_ram_din;
            else           b_ram_dout <= b_mem[b_ram_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds a word on instance A until accepted; the write commits at the next tick.
    task automatic push_a(input logic [7:0] d);
        bit ok;
        ok = 1'b0;
        tick();
        a_in_valid = 1'b1;
        a_in_data  = d;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (n > 0) tick();
            #1;
            ok = a_in_ready;
        end
        if (!ok) check_val("push_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, got, mcount, seen;
        logic [7:0] e;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;

        // Reset / idle
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_val("rst_flags", 32'({a_in_ready, a_ram_en, a_empty, a_full}), 32'b0010);
            check_val("rst_count", 32'(a_count), 32'd0);
        end
        tick(); rst = 1'b0; #1;
        check_val("idle_ov",    32'(a_out_valid), 32'd0);
        check_val("idle_empty", 32'(a_empty),     32'd1);
        check_val("idle_count", 32'(a_count),    32'd0);
        check_val("idle_rdy",   32'(a_in_ready),  32'd1);
        check_val("idle_en",    32'(a_ram_en),    32'd0);

        // Single word
        tick(); a_in_valid = 1'b1; a_in_data = 8'hA5; #1;
        check_val("sw_wr",   32'({a_ram_en, a_ram_wen}), 32'b11);
        check_val("sw_wadr", 32'(a_ram_addr), 32'd0);
        tick(); a_in_valid = 1'b0; #1;
        check_val("sw_rd",   32'({a_ram_en, a_ram_wen}), 32'b10);
        check_val("sw_radr", 32'(a_ram_addr), 32'd0);
        check_val("sw_cnt1", 32'(a_count), 32'd1);
        check_val("sw_ov0",  32'(a_out_valid), 32'd0);
        tick(); #1;
        check_val("sw_ov1",  32'(a_out_valid), 32'd1);
        check_val("sw_data", 32'(a_out_data), 32'hA5);
        check_val("sw_cnt2", 32'(a_count), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick(); #1;
            check_val("sw_hold", 32'({a_out_valid, a_out_data}), 32'h1A5);
        end
        tick(); a_out_ready = 1'b1; #1;
        tick(); a_out_ready = 1'b0; #1;
        check_val("sw_empty", 32'(a_empty), 32'd1);

        // Fill to full, then drain; full blocks writes even while popping
        for (int i = 0; i < 9; i++) push_a(8'(i));
        tick(); a_in_valid = 1'b1; a_in_data = 8'hFF; a_out_ready = 1'b1; #1;
        check_val("full_cnt", 32'(a_count), 32'd9);
        check_val("full_flag", 32'(a_full), 32'd1);
        check_val("full_rdy", 32'(a_in_ready), 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) begin tick(); a_in_valid = 1'b0; #1; end
            check_val("drain_v", 32'(a_out_valid), 32'd1);
            check_val("drain_d", 32'(a_out_data), 32'(i));
        end
        tick(); a_in_valid = 1'b0; a_out_ready = 1'b0; #1;
        check_val("drain_empty", 32'(a_empty), 32'd1);

        // Contention: 100 words, producer and consumer always active
        sent = 0; got = 0; q.delete();
        for (int n = 0; n < 1000 && got < 100; n++) begin
            tick(); a_in_valid = (sent < 100); a_in_data = 8'(sent * 7 + 3); a_out_ready = 1'b1; #1;
            check_val("cont_rdy", 32'(a_in_ready), 32'(!(a_ram_en && !a_ram_wen)));
            if (a_in_valid && a_in_ready) begin q.push_back(a_in_data); sent++; end
            if (a_out_valid && a_out_ready) begin
                if (q.size() == 0) check_val("cont_under", 32'd1, 32'd0);
                else begin e = q.pop_front(); check_val("cont_d", 32'(a_out_data), 32'(e)); end
                got++;
            end
        end
        check_val("cont_n", 32'(got), 32'd100);
        tick(); a_in_valid = 1'b0; a_out_ready = 1'b0; #1;
        check_val("cont_empty", 32'(a_empty), 32'd1);

        // DEPTH=6 random traffic against a scoreboard and occupancy model
        sent = 0; got = 0; mcount = 0; q.delete();
        for (int n = 0; n < 20000 && got < 1000; n++) begin
            tick();
            b_in_valid  = (sent < 1000) && 1'($urandom_range(1, 0));
            b_in_data   = 8'($urandom);
            b_out_ready = 1'($urandom_range(1, 0));
            #1;
            check_val("b_cnt", 32'(b_count), 32'(mcount));
            if (b_ram_en) check_val("b_addr", 32'(b_ram_addr <= 3'd5), 32'd1);
            if (b_in_valid && b_in_ready) begin q.push_back(b_in_data); sent++; mcount++; end
            if (b_out_valid && b_out_ready) begin
                if (q.size() == 0) check_val("b_under", 32'd1, 32'd0);
                else begin e = q.pop_front(); check_val("b_d", 32'(b_out_data), 32'(e)); end
                got++; mcount--;
            end
        end
        check_val("b_n", 32'(got), 32'd1000);
        tick(); b_in_valid = 1'b0; b_out_ready = 1'b0; #1;

        // Mid-operation reset
        for (int i = 0; i < 5; i++) push_a(8'(8'h50 + i));
        tick(); a_in_valid = 1'b0; #1;
        check_val("mr_cnt5", 32'(a_count), 32'd5);
        tick(); rst = 1'b1; #1;
        check_val("mr_rst", 32'({a_in_ready, a_ram_en, a_empty}), 32'b001);
        check_val("mr_rcnt", 32'(a_count), 32'd0);
        tick(); rst = 1'b0; #1;
        check_val("mr_cnt0", 32'(a_count), 32'd0);
        check_val("mr_ov", 32'(a_out_valid), 32'd0);
        push_a(8'h3C);
        seen = 0;
        for (int n = 0; n < 10 && seen == 0; n++) begin
            tick(); a_in_valid = 1'b0; #1;
            if (a_out_valid) seen = 1;
        end
        check_val("mr_ov1", 32'(a_out_valid), 32'd1);
        check_val("mr_data", 32'(a_out_data), 32'h3C);
        check_val("mr_cnt1", 32'(a_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
